// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: I2S / left-justified bit clock and framing generator.
//
// Derives clk_bit and clk_ws from clk_ref using a runtime half-period
// divider, and emits single-cycle clk_ref strobes that mark the clk_bit
// edges for the shifters. Divider and justification mode are latched only
// at frame start, so a frame is never distorted by a mid-frame change.
//
// Ports:
//   clk_ref      reference clock, all outputs registered on its rising edge
//   reset        synchronous, active-high
//   enable       run request (start/stop aligned to frame boundaries)
//   half_period  clk_ref cycles per clk_bit half period (<2 clamps to 2)
//   mode_lj      0 = I2S (ws one bit early), 1 = left-justified
//   clk_bit      bit clock
//   clk_ws       word select
//   tx_shift     strobe at each clk_bit falling edge and at frame start
//   rx_sample    strobe at each clk_bit rising edge
//   frame_start  strobe with the tx_shift of ch0/bit0
//   sample_req   strobe with the tx_shift entering the last slot of a frame
//   bit_idx      current bit slot (0 = MSB)
//   ch_idx       current channel slot
//   busy         a frame is in progress
module i2s_clk_gen #(
  parameter int DIV_WIDTH   = 8,
  parameter int BITS_PER_CH = 24,
  parameter int NUM_CH      = 2,
  localparam int BIT_W = (BITS_PER_CH > 2) ? $clog2(BITS_PER_CH) : 1,
  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_ref,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic                 mode_lj,
  output logic                 clk_bit,
  output logic                 clk_ws,
  output logic                 tx_shift,
  output logic                 rx_sample,
  output logic                 frame_start,
  output logic                 sample_req,
  output logic [BIT_W-1:0]     bit_idx,
  output logic [CH_W-1:0]      ch_idx,
  output logic                 busy
);

  localparam int CNT_W = (DIV_WIDTH < 2) ? 2 : DIV_WIDTH;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_HALF  = CH_W'(NUM_CH / 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt;
  logic             lj_lat;

  logic [CNT_W-1:0] hp_ext;
  logic [CNT_W-1:0] hp_clamp;
  logic             half_done;
  logic             bit_last;
  logic             ch_last;
  logic             frame_end;
  logic [BIT_W-1:0] bit_nxt;
  logic [CH_W-1:0]  ch_slot_nxt;
  logic [CH_W-1:0]  ch_nxt;

  always_comb begin
    hp_ext      = CNT_W'(half_period);
    hp_clamp    = (hp_ext < CNT_W'(2)) ? CNT_W'(2) : hp_ext;
    half_done   = (cnt == n_lat - CNT_W'(1));
    bit_last    = (bit_idx == BIT_LAST);
    ch_last     = (ch_idx == CH_LAST);
    frame_end   = bit_last && ch_last;
    bit_nxt     = bit_last ? '0 : bit_idx + BIT_W'(1);
    ch_slot_nxt = ch_last ? '0 : ch_idx + CH_W'(1);
    ch_nxt      = bit_last ? ch_slot_nxt : ch_idx;
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state       <= IDLE;
      n_lat       <= '0;
      cnt         <= '0;
      lj_lat      <= 1'b0;
      clk_bit     <= 1'b0;
      clk_ws      <= 1'b0;
      tx_shift    <= 1'b0;
      rx_sample   <= 1'b0;
      frame_start <= 1'b0;
      sample_req  <= 1'b0;
      bit_idx     <= '0;
      ch_idx      <= '0;
      busy        <= 1'b0;
    end else begin
      tx_shift    <= 1'b0;
      rx_sample   <= 1'b0;
      frame_start <= 1'b0;
      sample_req  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= RUN;
            n_lat       <= hp_clamp;
            lj_lat      <= mode_lj;
            cnt         <= '0;
            clk_bit     <= 1'b0;
            clk_ws      <= 1'b0;
            bit_idx     <= '0;
            ch_idx      <= '0;
            busy        <= 1'b1;
            tx_shift    <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          // Only the label follows enable mid-frame; the frame itself runs on.
          if (state == RUN && !enable)
            state <= DRAIN;
          else if (state == DRAIN && enable)
            state <= RUN;

          if (!half_done) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (!clk_bit) begin
              clk_bit   <= 1'b1;
              rx_sample <= 1'b1;
            end else if (frame_end) begin
              clk_bit <= 1'b0;
              clk_ws  <= 1'b0;
              bit_idx <= '0;
              ch_idx  <= '0;
              if (enable) begin
                // Back-to-back frame: new settings apply from here.
                state       <= RUN;
                n_lat       <= hp_clamp;
                lj_lat      <= mode_lj;
                tx_shift    <= 1'b1;
                frame_start <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              clk_bit  <= 1'b0;
              tx_shift <= 1'b1;
              bit_idx  <= bit_nxt;
              ch_idx   <= ch_nxt;
              if (bit_nxt == BIT_LAST && ch_last)
                sample_req <= 1'b1;
              if (lj_lat)
                clk_ws <= (ch_nxt >= CH_HALF);
              else if (bit_nxt == BIT_LAST)
                // I2S: ws switches one slot ahead of the channel it announces.
                clk_ws <= (ch_slot_nxt >= CH_HALF);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clk_gen.sv
module tb_i2s_clk_gen;

  localparam int S_FS = 0, S_TX = 1, S_RX = 2, S_BCLK = 3, S_WS = 4, S_SREQ = 5,
                 S_BIT = 6, S_CH = 7, S_BUSY = 8, S_NTX = 9, S_NRX = 10, S_NFS = 11,
                 S2_FS = 12, S2_CH = 13, S2_BIT = 14, S2_WS = 15, S2_SREQ = 16;

  logic       clk_ref;
  logic       reset, enable, mode_lj;
  logic [7:0] half_period;
  logic       clk_bit, clk_ws, tx_shift, rx_sample, frame_start, sample_req, busy;
  logic [4:0] bit_idx;
  logic [0:0] ch_idx;

  logic       r2, en2, lj2;
  logic [7:0] hp2;
  logic       clk_bit2, clk_ws2, tx_shift2, rx_sample2, frame_start2, sample_req2, busy2;
  logic [3:0] bit_idx2;
  logic [1:0] ch_idx2;

  i2s_clk_gen #(.DIV_WIDTH(8), .BITS_PER_CH(24), .NUM_CH(2)) dut (
    .clk_ref(clk_ref), .reset(reset), .enable(enable), .half_period(half_period),
    .mode_lj(mode_lj), .clk_bit(clk_bit), .clk_ws(clk_ws), .tx_shift(tx_shift),
    .rx_sample(rx_sample), .frame_start(frame_start), .sample_req(sample_req),
    .bit_idx(bit_idx), .ch_idx(ch_idx), .busy(busy));

  i2s_clk_gen #(.DIV_WIDTH(8), .BITS_PER_CH(16), .NUM_CH(4)) dut4 (
    .clk_ref(clk_ref), .reset(r2), .enable(en2), .half_period(hp2),
    .mode_lj(lj2), .clk_bit(clk_bit2), .clk_ws(clk_ws2), .tx_shift(tx_shift2),
    .rx_sample(rx_sample2), .frame_start(frame_start2), .sample_req(sample_req2),
    .bit_idx(bit_idx2), .ch_idx(ch_idx2), .busy(busy2));

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];
  int   abs_cyc = 0;
  int   base = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tx = 0, n_rx = 0, n_fs = 0, n_ovl = 0;

  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  function automatic string sig_name(input int s);
    case (s)
      S_FS: return "frame_start";  S_TX: return "tx_shift";    S_RX: return "rx_sample";
      S_BCLK: return "clk_bit";    S_WS: return "clk_ws";      S_SREQ: return "sample_req";
      S_BIT: return "bit_idx";     S_CH: return "ch_idx";      S_BUSY: return "busy";
      S_NTX: return "tx_count";    S_NRX: return "rx_count";   S_NFS: return "fs_count";
      S2_FS: return "frame_start4"; S2_CH: return "ch_idx4";   S2_BIT: return "bit_idx4";
      S2_WS: return "clk_ws4";     S2_SREQ: return "sample_req4";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] get(input int s);
    case (s)
      S_FS: return 32'(frame_start);   S_TX: return 32'(tx_shift);   S_RX: return 32'(rx_sample);
      S_BCLK: return 32'(clk_bit);     S_WS: return 32'(clk_ws);     S_SREQ: return 32'(sample_req);
      S_BIT: return 32'(bit_idx);      S_CH: return 32'(ch_idx);     S_BUSY: return 32'(busy);
      S_NTX: return 32'(n_tx);         S_NRX: return 32'(n_rx);      S_NFS: return 32'(n_fs);
      S2_FS: return 32'(frame_start2); S2_CH: return 32'(ch_idx2);   S2_BIT: return 32'(bit_idx2);
      S2_WS: return 32'(clk_ws2);      S2_SREQ: return 32'(sample_req2);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
    end
  endtask

  // Keep the scoreboard ordered by cycle so the monitor only looks at the head.
  task automatic push_exp(input int c, input int s, input int v);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = s; e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    int   rel;
    forever begin
      @(posedge clk_ref);
      abs_cyc++;
      #1;
      rel = abs_cyc - base;
      if (rel == 0) begin
        n_tx = 0; n_rx = 0; n_fs = 0;
      end
      if (tx_shift === 1'b1) n_tx++;
      if (rx_sample === 1'b1) n_rx++;
      if (frame_start === 1'b1) n_fs++;
      if (tx_shift === 1'b1 && rx_sample === 1'b1) n_ovl++;
      while (sb.size() > 0 && sb[0].cyc <= rel) begin
        e = sb.pop_front();
        check_val($sformatf("%s@%0d", sig_name(e.sig), e.cyc), get(e.sig), 32'(e.val));
      end
    end
  end

  task automatic start_scn();
    base = abs_cyc + 1;
  endtask

  task automatic wait_rel(input int n);
    for (int k = 0; k < 20000 && (abs_cyc - base) < n; k++) @(negedge clk_ref);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && sb.size() > 0; k++) @(negedge clk_ref);
    check_val("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; half_period = 8'd4; mode_lj = 1'b0;
    r2 = 1'b1; en2 = 1'b0; hp2 = 8'd3; lj2 = 1'b0;
    repeat (2) @(negedge clk_ref);

    // Reset state, then idle with enable low.
    start_scn();
    for (int s = S_FS; s <= S_BUSY; s++) push_exp(0, s, 0);
    push_exp(3, S_BCLK, 0); push_exp(3, S_BUSY, 0); push_exp(3, S_TX, 0); push_exp(3, S_FS, 0);
    wait_rel(1);
    reset = 1'b0;
    wait_rel(4);
    drain();

    // A: I2S N=4; half_period->6 mid frame 1, mode->LJ mid frame 2, stop mid frame 3.
    start_scn();
    push_exp(0, S_FS, 1); push_exp(0, S_TX, 1); push_exp(0, S_BUSY, 1);
    push_exp(0, S_BIT, 0); push_exp(0, S_CH, 0); push_exp(0, S_BCLK, 0); push_exp(0, S_RX, 0);
    push_exp(3, S_BCLK, 0); push_exp(4, S_BCLK, 1); push_exp(4, S_RX, 1); push_exp(4, S_TX, 0);
    push_exp(5, S_RX, 0); push_exp(8, S_BCLK, 0); push_exp(8, S_TX, 1); push_exp(8, S_BIT, 1);
    push_exp(183, S_WS, 0); push_exp(184, S_WS, 1); push_exp(184, S_BIT, 23); push_exp(184, S_CH, 0);
    push_exp(192, S_CH, 1); push_exp(192, S_BIT, 0); push_exp(196, S_BCLK, 1);
    push_exp(375, S_WS, 1); push_exp(375, S_SREQ, 0);
    push_exp(376, S_WS, 0); push_exp(376, S_SREQ, 1); push_exp(376, S_BIT, 23); push_exp(376, S_CH, 1);
    push_exp(383, S_FS, 0); push_exp(383, S_NTX, 48); push_exp(383, S_NRX, 48); push_exp(383, S_NFS, 1);
    push_exp(384, S_FS, 1); push_exp(384, S_TX, 1); push_exp(384, S_BIT, 0); push_exp(384, S_BUSY, 1);
    push_exp(389, S_BCLK, 0); push_exp(390, S_BCLK, 1); push_exp(390, S_RX, 1);
    push_exp(395, S_BCLK, 1); push_exp(396, S_BCLK, 0); push_exp(396, S_TX, 1);
    push_exp(659, S_WS, 0); push_exp(660, S_WS, 1);
    push_exp(960, S_FS, 1); push_exp(1236, S_WS, 0); push_exp(1247, S_WS, 0); push_exp(1248, S_WS, 1);
    push_exp(1248, S_CH, 1); push_exp(1524, S_SREQ, 1);
    push_exp(1535, S_BUSY, 1); push_exp(1535, S_BCLK, 1); push_exp(1535, S_CH, 1); push_exp(1535, S_BIT, 23);
    push_exp(1536, S_BUSY, 0); push_exp(1536, S_BCLK, 0); push_exp(1536, S_FS, 0); push_exp(1536, S_TX, 0);
    push_exp(1536, S_WS, 0); push_exp(1536, S_CH, 0); push_exp(1536, S_BIT, 0);
    push_exp(1540, S_BCLK, 0); push_exp(1540, S_RX, 0);
    enable = 1'b1; half_period = 8'd4; mode_lj = 1'b0;
    wait_rel(99);  half_period = 8'd6;
    wait_rel(499); mode_lj = 1'b1;
    wait_rel(999); enable = 1'b0;
    wait_rel(1545);
    drain();

    // B: enable drops at 100 and returns at 200; later drops at 500 for good.
    half_period = 8'd4; mode_lj = 1'b0;
    start_scn();
    push_exp(0, S_FS, 1); push_exp(99, S_BUSY, 1); push_exp(150, S_BCLK, 1); push_exp(200, S_BUSY, 1);
    push_exp(376, S_SREQ, 1); push_exp(384, S_FS, 1); push_exp(384, S_TX, 1); push_exp(384, S_BUSY, 1);
    push_exp(384, S_BIT, 0); push_exp(388, S_RX, 1); push_exp(760, S_SREQ, 1); push_exp(767, S_BUSY, 1);
    push_exp(768, S_BUSY, 0); push_exp(768, S_FS, 0); push_exp(768, S_TX, 0); push_exp(768, S_BCLK, 0);
    push_exp(768, S_CH, 0); push_exp(772, S_BCLK, 0); push_exp(772, S_RX, 0); push_exp(800, S_BUSY, 0);
    enable = 1'b1;
    wait_rel(99);  enable = 1'b0;
    wait_rel(199); enable = 1'b1;
    wait_rel(499); enable = 1'b0;
    wait_rel(805);
    drain();

    // C: half_period=1 clamps to 2; reset mid frame; restart with half_period=0.
    start_scn();
    push_exp(0, S_FS, 1); push_exp(0, S_TX, 1); push_exp(1, S_BCLK, 0); push_exp(2, S_BCLK, 1);
    push_exp(2, S_RX, 1); push_exp(3, S_BCLK, 1); push_exp(4, S_BCLK, 0); push_exp(4, S_TX, 1);
    push_exp(4, S_BIT, 1); push_exp(6, S_RX, 1);
    push_exp(149, S_WS, 1); push_exp(149, S_CH, 1); push_exp(149, S_BIT, 13); push_exp(149, S_BUSY, 1);
    for (int s = S_FS; s <= S_BUSY; s++) push_exp(150, s, 0);
    for (int c = 151; c <= 152; c++) begin
      push_exp(c, S_BUSY, 0); push_exp(c, S_TX, 0); push_exp(c, S_FS, 0); push_exp(c, S_RX, 0);
    end
    push_exp(156, S_FS, 1); push_exp(156, S_TX, 1); push_exp(156, S_BIT, 0); push_exp(156, S_CH, 0);
    push_exp(156, S_BUSY, 1); push_exp(157, S_BCLK, 0); push_exp(158, S_BCLK, 1); push_exp(158, S_RX, 1);
    push_exp(160, S_BCLK, 0); push_exp(160, S_TX, 1); push_exp(160, S_BIT, 1); push_exp(171, S_BUSY, 0);
    half_period = 8'd1; enable = 1'b1;
    wait_rel(149); reset = 1'b1; enable = 1'b0;
    wait_rel(151); reset = 1'b0;
    wait_rel(155); enable = 1'b1; half_period = 8'd0;
    wait_rel(170); reset = 1'b1; enable = 1'b0;
    wait_rel(173);
    drain();
    reset = 1'b0;

    // D: 4 channels x 16 bits, N=3, I2S.
    r2 = 1'b0;
    repeat (2) @(negedge clk_ref);
    start_scn();
    push_exp(0, S2_FS, 1); push_exp(0, S2_CH, 0); push_exp(95, S2_CH, 0); push_exp(96, S2_CH, 1);
    push_exp(96, S2_BIT, 0); push_exp(185, S2_WS, 0); push_exp(186, S2_WS, 1); push_exp(186, S2_BIT, 15);
    push_exp(186, S2_CH, 1); push_exp(192, S2_CH, 2); push_exp(288, S2_CH, 3); push_exp(300, S2_WS, 1);
    push_exp(377, S2_WS, 1); push_exp(378, S2_WS, 0); push_exp(378, S2_SREQ, 1);
    push_exp(383, S2_FS, 0); push_exp(383, S2_CH, 3); push_exp(384, S2_FS, 1); push_exp(384, S2_CH, 0);
    en2 = 1'b1; hp2 = 8'd3; lj2 = 1'b0;
    wait_rel(390);
    drain();
    en2 = 1'b0;

    check_val("tx_rx_overlap", 32'(n_ovl), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_clk_gen.md
Name: i2s_clk_gen

Overview:
- Parametrised I2S/left-justified clock and framing generator, derived from a single fast reference clock.
- Outputs: bit clock (clk_bit), word select (clk_ws), and one-cycle clk_ref-domain strobes with slot indices that drive the serializer/deserializer.
- Programmable at runtime through a divider and a justification mode; both take effect on frame boundaries.
- Sits between the system clock and the audio TX/RX shifters; sample_req tells the upstream source when to present the next frame.

Parameters:
- DIV_WIDTH, 8: width of the runtime half-period divider.
- BITS_PER_CH, 24: bit slots per channel (>=2).
- NUM_CH, 2: channels per frame (even, >=2). First half of the channels has ws=0; second half has ws=1.

Ports:
- clk_ref  in  1  reference clock; every output changes only on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; start and stop are frame-aligned.
- half_period  in  DIV_WIDTH  clk_ref cycles per clk_bit half period; values <2 are clamped to 2.
- mode_lj  in  1  0 = I2S (ws leads MSB by one bit); 1 = left-justified.
- clk_bit  out  1  bit clock.
- clk_ws  out  1  word select.
- tx_shift  out  1  one-cycle strobe at each clk_bit falling edge and at frame start; transmitter updates its data here.
- rx_sample  out  1  one-cycle strobe at each clk_bit rising edge; receiver samples its data here.
- frame_start  out  1  one-cycle strobe with the tx_shift of ch0/bit0.
- sample_req  out  1  one-cycle strobe with the tx_shift of the last bit of the frame.
- bit_idx  out  max(1,$clog2(BITS_PER_CH))  current bit slot; 0 = MSB.
- ch_idx  out  max(1,$clog2(NUM_CH))  current channel slot.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: all outputs 0. The state machine enters IDLE.
- States:
  - IDLE: clk_bit=0, clk_ws=0, counters held at 0.
  - RUN: generating frames.
  - DRAIN: finishing the current frame after enable drops.
- IDLE -> RUN when enable=1 on a rising edge:
  - Latch N = max(half_period, 2) and mode_lj.
  - Same cycle: assert tx_shift and frame_start; set bit_idx=0, ch_idx=0, busy=1.
- Half-period counter (0..N-1) advances every cycle in RUN/DRAIN. At N-1 it wraps and clk_bit toggles.
  - Toggle 0->1: rx_sample pulses in the same cycle the registered clk_bit goes high.
  - Toggle 1->0: tx_shift pulses; bit_idx advances.
- Slot indexing:
  - bit_idx wraps BITS_PER_CH-1 -> 0 and increments ch_idx.
  - ch_idx wraps NUM_CH-1 -> 0; that tx_shift is a frame boundary.
- Frame length = 2*N*BITS_PER_CH*NUM_CH clk_ref cycles.
- clk_ws, left-justified: 1 iff ch_idx >= NUM_CH/2; updated in the same cycle as ch_idx.
- clk_ws, I2S: updated at the tx_shift where bit_idx becomes BITS_PER_CH-1. Takes the value the next slot's channel will have (ch_idx+1 mod NUM_CH), so ws leads the MSB by one bit period.
- sample_req pulses with the tx_shift entering ch_idx=NUM_CH-1, bit_idx=BITS_PER_CH-1.
- At a frame boundary in RUN:
  - enable=1: re-latch N and mode_lj, pulse frame_start, continue with no gap.
  - enable=0: go to IDLE. clk_bit is already 0. Drive clk_ws=0 and counters 0; drop busy; suppress tx_shift and frame_start.
- enable falling mid-frame: RUN -> DRAIN. The frame completes unchanged.
  - enable re-rising before the boundary returns the block to RUN with no gap.
- half_period and mode_lj changes mid-frame are ignored until the next boundary.
- reset asserted mid-frame: all outputs 0 on the next edge; IDLE. No partial strobes are emitted afterwards.
- tx_shift and rx_sample never assert in the same cycle.
- Strobes are registered outputs, aligned with the clk_bit edge they mark.

Test Plan:
- Reset, enable=1, half_period=4, BITS=24, NUM_CH=2, I2S:
  - frame_start at cycle 0; first rx_sample at cycle 4.
  - tx_shift every 8 cycles; next frame_start at cycle 384.
  - clk_bit period 8.
- Same setup, ws timing:
  - I2S: clk_ws rises at cycle 8*23=184 (tx_shift entering ch0/bit23) and falls at 376.
  - Left-justified: clk_ws rises at 192.
  - sample_req at cycle 376.
- half_period=0 and half_period=1 -> clk_bit period 4 cycles (clamped to 2). half_period changed 4->6 mid-frame -> period stays 8 until the boundary at 384, then becomes 12.
- enable dropped at cycle 100 -> frame completes; clk_bit stays 0 after cycle 384; busy=0 from 384; no frame_start. enable re-asserted at 200 -> frame continues seamlessly.
- reset asserted at cycle 150 mid-frame -> next cycle all outputs 0 and no strobes. Re-enable -> frame_start immediately, bit_idx=0, ch_idx=0.
- NUM_CH=4, BITS=16, half_period=3:
  - ch_idx sequence 0..3; frame length 384 cycles.
  - clk_ws=1 for ch2/ch3; I2S rise at the tx_shift entering ch1/bit15 (cycle 6*31=186).
